// File: rtl/i2c_pkg.sv
// i2c_pkg
// Definitions shared by the I2C target and the I2C controller.
//   i2c_state_t        : target FSM state encoding
//   CLK_HZ             : nominal system clock frequency
//   SCL_HZ_STD         : standard-mode bus rate (100 kHz)
//   SCL_HZ_FAST_PLUS   : fast-mode-plus bus rate (1 MHz)
//   scl_quarter_cycles : system clocks per quarter SCL period at a given bus rate
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ACK_ADDR,
    WR_BYTE,
    ACK_WR,
    RD_BYTE,
    RD_ACK,
    WAIT_STOP
  } i2c_state_t;

  localparam int unsigned CLK_HZ           = 40_000_000;
  localparam int unsigned SCL_HZ_STD       = 100_000;
  localparam int unsigned SCL_HZ_FAST_PLUS = 1_000_000;

  // A bit cell is four quarter periods: data setup, scl high, sample, scl low.
  function automatic int unsigned scl_quarter_cycles(input int unsigned scl_hz);
    return CLK_HZ / (4 * scl_hz);
  endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// i2c_bus_sync
// Brings the asynchronous scl/sda bus lines into the clk domain and derives
// edge and bus-condition pulses from them.
//   clk, rst     : system clock, synchronous active-high reset
//   scl_in       : raw scl from the bus
//   sda_in       : raw sda from the bus
//   sda_level    : synchronized sda level
//   scl_rise     : one-cycle pulse on a synchronized scl rising edge
//   scl_fall     : one-cycle pulse on a synchronized scl falling edge
//   start_det    : sda fell while scl stayed high (START / repeated START)
//   stop_det     : sda rose while scl stayed high (STOP)
// SYNC_STAGES must be at least 2.
module i2c_bus_sync
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic scl_in,
  input  logic sda_in,
  output logic sda_level,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [SYNC_STAGES-1:0] scl_pipe;
  logic [SYNC_STAGES-1:0] sda_pipe;
  logic                   scl_hist;
  logic                   sda_hist;
  logic                   scl_now;
  logic                   sda_now;

  // Synchronizer chains plus one history flop per line. Everything presets to
  // 1 (idle bus level) so that leaving reset never looks like a bus edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_pipe <= '1;
      sda_pipe <= '1;
      scl_hist <= 1'b1;
      sda_hist <= 1'b1;
    end else begin
      scl_pipe <= {scl_pipe[SYNC_STAGES-2:0], scl_in};
      sda_pipe <= {sda_pipe[SYNC_STAGES-2:0], sda_in};
      scl_hist <= scl_pipe[SYNC_STAGES-1];
      sda_hist <= sda_pipe[SYNC_STAGES-1];
    end
  end

  assign scl_now   = scl_pipe[SYNC_STAGES-1];
  assign sda_now   = sda_pipe[SYNC_STAGES-1];
  assign sda_level = sda_now;

  // Conditions require scl high in both the current and previous sample so a
  // data change racing an scl edge is never mistaken for START or STOP.
  assign scl_rise  =  scl_now & ~scl_hist;
  assign scl_fall  = ~scl_now &  scl_hist;
  assign start_det =  scl_now &  scl_hist &  sda_hist & ~sda_now;
  assign stop_det  =  scl_now &  scl_hist & ~sda_hist &  sda_now;

endmodule

// File: rtl/i2c_target_regfile.sv
// i2c_target_regfile
// I2C target with an internal byte register file and auto-incrementing pointer.
// A write transaction's first data byte sets the pointer; following bytes are
// stored at the pointer, which then increments. Reads stream bytes from the
// pointer until the controller NACKs.
//   clk, rst   : system clock, synchronous active-high reset
//   scl        : bus clock (input only, the target never stretches)
//   sda        : open-drain bus data, driven 0 or released
//   rd_addr    : local read-port index
//   rd_data    : regs[rd_addr], combinational
//   wr_valid   : one-cycle pulse when a bus write stores a register
//   wr_addr    : index stored (valid with wr_valid)
//   wr_data    : byte stored (valid with wr_valid)
//   busy       : high from START until STOP or address mismatch
//   ack_error  : sticky, controller NACKed a read; cleared by the next START
module i2c_target_regfile
  import i2c_pkg::*;
#(
  parameter logic [6:0] ADDRS       = 7'b1101101,
  parameter int         REG_AW      = 4,
  parameter int         SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              scl,
  inout  wire               sda,
  input  logic [REG_AW-1:0] rd_addr,
  output logic [7:0]        rd_data,
  output logic              wr_valid,
  output logic [REG_AW-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy,
  output logic              ack_error
);

  localparam int              NREGS   = 1 << REG_AW;
  localparam logic [REG_AW-1:0] PTR_ONE = {{(REG_AW-1){1'b0}}, 1'b1};

  logic scl_rise;
  logic scl_fall;
  logic start_det;
  logic stop_det;
  logic sda_s;

  i2c_state_t        state;
  logic [7:0]        shift;
  logic [3:0]        bit_cnt;
  logic [REG_AW-1:0] ptr;
  logic              first_byte;
  logic              sda_low;
  logic [7:0]        regs [NREGS];

  i2c_bus_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk       (clk),
    .rst       (rst),
    .scl_in    (scl),
    .sda_in    (sda),
    .sda_level (sda_s),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  // Open drain: only ever pull low, otherwise release to the pull-up.
  assign sda     = sda_low ? 1'b0 : 1'bz;
  assign rd_data = regs[rd_addr];

  // Protocol FSM. START/STOP override everything else in the same cycle.
  // bit_cnt counts scl rising edges inside a byte; the falling edge that
  // follows the 8th rise is where each byte is resolved. ACK states need no
  // count: their first falling edge is always the end of the 9th clock.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      shift      <= 8'h00;
      bit_cnt    <= 4'd0;
      ptr        <= '0;
      first_byte <= 1'b0;
      sda_low    <= 1'b0;
      busy       <= 1'b0;
      ack_error  <= 1'b0;
      wr_valid   <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= 8'h00;
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= 8'h00;
      end
    end else begin
      wr_valid <= 1'b0;
      if (start_det) begin
        state     <= ADDR;
        bit_cnt   <= 4'd0;
        busy      <= 1'b1;
        ack_error <= 1'b0;
        sda_low   <= 1'b0;
      end else if (stop_det) begin
        state   <= IDLE;
        busy    <= 1'b0;
        sda_low <= 1'b0;
      end else begin
        case (state)
          IDLE, WAIT_STOP: begin
            sda_low <= 1'b0;
          end

          ADDR: begin
            if (scl_rise) begin
              shift   <= {shift[6:0], sda_s};
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall && bit_cnt == 4'd8) begin
              bit_cnt <= 4'd0;
              if (shift[7:1] == ADDRS) begin
                state   <= ACK_ADDR;
                sda_low <= 1'b1;
              end else begin
                state   <= IDLE;
                busy    <= 1'b0;
                sda_low <= 1'b0;
              end
            end
          end

          ACK_ADDR: begin
            if (scl_fall) begin
              if (shift[0]) begin
                state   <= RD_BYTE;
                shift   <= regs[ptr];
                sda_low <= ~regs[ptr][7];
              end else begin
                state      <= WR_BYTE;
                first_byte <= 1'b1;
                sda_low    <= 1'b0;
              end
            end
          end

          WR_BYTE: begin
            if (scl_rise) begin
              shift   <= {shift[6:0], sda_s};
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall && bit_cnt == 4'd8) begin
              bit_cnt <= 4'd0;
              sda_low <= 1'b1;
              state   <= ACK_WR;
              if (first_byte) begin
                ptr        <= shift[REG_AW-1:0];
                first_byte <= 1'b0;
              end else begin
                regs[ptr] <= shift;
                wr_valid  <= 1'b1;
                wr_addr   <= ptr;
                wr_data   <= shift;
                ptr       <= ptr + PTR_ONE;
              end
            end
          end

          ACK_WR: begin
            if (scl_fall) begin
              sda_low <= 1'b0;
              state   <= WR_BYTE;
            end
          end

          // The MSB was already placed on the bus when this state was entered,
          // so each falling edge moves on to the next lower bit.
          RD_BYTE: begin
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                bit_cnt <= 4'd0;
                sda_low <= 1'b0;
                state   <= RD_ACK;
                ptr     <= ptr + PTR_ONE;
              end else begin
                shift   <= {shift[6:0], 1'b0};
                sda_low <= ~shift[6];
              end
            end
          end

          RD_ACK: begin
            if (scl_rise) begin
              if (sda_s) begin
                ack_error <= 1'b1;
                state     <= WAIT_STOP;
              end
            end else if (scl_fall) begin
              state   <= RD_BYTE;
              shift   <= regs[ptr];
              sda_low <= ~regs[ptr][7];
            end
          end

          default: begin
            state   <= IDLE;
            sda_low <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
